// File: rtl/single_port_sync_ram_pkg.sv
// Shared defaults and small helpers for single_port_sync_ram instances
// such as LZW dictionary and code tables.
package single_port_sync_ram_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } ramOp_e;

    function automatic ramOp_e decodeOp(input logic cs, input logic we);
        if (!cs) begin
            return OP_IDLE;
        end
        return we ? OP_WRITE : OP_READ;
    endfunction

    function automatic logic addrInRange(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/single_port_sync_ram_if.sv
// Control side of the RAM port: address and strobes driven by the requester.
// The data bus itself is a bidirectional wire kept outside the interface.
interface single_port_sync_ram_if
    import single_port_sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] addr;
    logic                  cs;
    logic                  we;
    logic                  oe;

    modport master (
        output addr,
        output cs,
        output we,
        output oe
    );

    modport slave (
        input addr,
        input cs,
        input we,
        input oe
    );

endinterface

// File: rtl/single_port_sync_ram.sv
// Single-port synchronous RAM with registered read data and a shared
// tri-state data bus that the RAM drives only for an enabled read.
module single_port_sync_ram
    import single_port_sync_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    single_port_sync_ram_if.slave     bus,
    inout  wire  [DATA_WIDTH-1:0]     data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdQ;

    ramOp_e w_op;
    logic   w_addrValid;
    logic   w_busDrive;

    assign w_op        = decodeOp(bus.cs, bus.we);
    assign w_addrValid = addrInRange(32'(bus.addr), DEPTH);

    // Array write kept free of reset so it maps onto block RAM; reset only
    // suppresses the write, it never clears contents.
    always_ff @(posedge clk) begin
        if (!rst && w_op == OP_WRITE && w_addrValid) begin
            r_mem[bus.addr] <= data;
        end
    end

    // Output register; out-of-range reads return zero instead of stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdQ <= '0;
        end else if (w_op == OP_READ) begin
            r_rdQ <= w_addrValid ? r_mem[bus.addr] : '0;
        end
    end

    // Write wins over oe, so the RAM never fights the requester's write data.
    assign w_busDrive = !rst && bus.cs && bus.oe && !bus.we;
    assign data       = w_busDrive ? r_rdQ : 'z;

endmodule

// File: tb/tb_single_port_sync_ram.sv
// Self-checking bench for single_port_sync_ram: table-driven vectors plus
// hand sequences, with a scoreboard queue of expected bus values.
module tb_single_port_sync_ram;
    import single_port_sync_ram_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 12;
    localparam int NVEC  = 13;

    typedef struct {
        logic          cs;
        logic          we;
        logic          oe;
        logic [AW-1:0] addr;
        logic [DW-1:0] busIn;
        logic [DW-1:0] expBus;
        string         name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    wire  [DW-1:0] data;
    logic          tbDrive;
    logic [DW-1:0] tbData;

    int            checks;
    int            failures;
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] modelRdQ;
    vec_t          vecs [NVEC];

    single_port_sync_ram_if #(.ADDR_WIDTH(AW)) bus ();

    assign data = tbDrive ? tbData : 'z;

    single_port_sync_ram #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .data(data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic cs, input logic we, input logic oe,
                                   input logic [AW-1:0] addr, input logic [DW-1:0] busIn,
                                   input logic [DW-1:0] expBus, input string name);
        vec_t v;
        v.cs     = cs;
        v.we     = we;
        v.oe     = oe;
        v.addr   = addr;
        v.busIn  = busIn;
        v.expBus = expBus;
        v.name   = name;
        return v;
    endfunction

    // When the RAM must release the bus, the requester's probe value is expected.
    function automatic logic [DW-1:0] expectedBus(input logic cs, input logic we, input logic oe,
                                                  input logic rstV, input logic [DW-1:0] probe);
        return (!rstV && cs && oe && !we) ? modelRdQ : probe;
    endfunction

    task automatic driveControls(input logic cs, input logic we, input logic oe, input logic rstV,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.cs   = cs;
        bus.we   = we;
        bus.oe   = oe;
        bus.addr = addr;
        rst      = rstV;
        tbDrive  = rstV || !(cs && oe && !we);
        tbData   = wdata;
    endtask

    task automatic checkOutput(input string name);
        logic [DW-1:0] exp;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, bus=%h", name, data);
        end else begin
            exp = expQ.pop_front();
            if (data !== exp) begin
                failures++;
                $display("[TB] FAIL %s: bus=%h required=%h", name, data, exp);
            end
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic we, input logic oe, input logic rstV,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic hasExp, input logic [DW-1:0] expIn,
                                 input string name);
        driveControls(cs, we, oe, rstV, addr, wdata);
        if (rstV) begin
            modelRdQ = '0;
        end else if (cs && !we) begin
            modelRdQ = (int'(addr) < DEPTH) ? model[addr] : '0;
        end
        if (!rstV && cs && we && int'(addr) < DEPTH) begin
            model[addr] = wdata;
        end
        expQ.push_back(hasExp ? expIn : expectedBus(cs, we, oe, rstV, wdata));
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    // Changes strobes between edges to observe the purely combinational bus release.
    task automatic probeComb(input logic cs, input logic we, input logic oe,
                             input logic [DW-1:0] probe, input string name);
        driveControls(cs, we, oe, 1'b0, bus.addr, probe);
        expQ.push_back(expectedBus(cs, we, oe, 1'b0, probe));
        #1;
        checkOutput(name);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        modelRdQ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 'x;
        end

        vecs[0]  = mkVec(1'b1, 1'b1, 1'b0, 4'd2,  32'hABCDE123, 32'hABCDE123, "wr_addr2");
        vecs[1]  = mkVec(1'b1, 1'b0, 1'b1, 4'd2,  32'h00000000, 32'hABCDE123, "rd_addr2");
        vecs[2]  = mkVec(1'b1, 1'b0, 1'b0, 4'd2,  32'h5A5A5A5A, 32'h5A5A5A5A, "rd_oe0_z");
        vecs[3]  = mkVec(1'b0, 1'b0, 1'b1, 4'd2,  32'h0F0F0F0F, 32'h0F0F0F0F, "cs0_oe1_z");
        vecs[4]  = mkVec(1'b0, 1'b1, 1'b1, 4'd2,  32'h11223344, 32'h11223344, "cs0_we1_z");
        vecs[5]  = mkVec(1'b1, 1'b0, 1'b1, 4'd2,  32'h00000000, 32'hABCDE123, "idle_no_write");
        vecs[6]  = mkVec(1'b1, 1'b1, 1'b1, 4'd5,  32'h12345678, 32'h12345678, "wr_prio_addr5");
        vecs[7]  = mkVec(1'b1, 1'b0, 1'b1, 4'd5,  32'h00000000, 32'h12345678, "rd_addr5");
        vecs[8]  = mkVec(1'b1, 1'b1, 1'b0, 4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, "wr_oor14");
        vecs[9]  = mkVec(1'b1, 1'b0, 1'b1, 4'd14, 32'h00000000, 32'h00000000, "rd_oor14");
        vecs[10] = mkVec(1'b1, 1'b0, 1'b1, 4'd2,  32'h00000000, 32'hABCDE123, "rd_addr2_kept");
        vecs[11] = mkVec(1'b0, 1'b0, 1'b0, 4'd0,  32'hC3C3C3C3, 32'hC3C3C3C3, "idle_z");
        vecs[12] = mkVec(1'b1, 1'b0, 1'b1, 4'd15, 32'h00000000, 32'h00000000, "rd_oor15");

        // Reset state: bus released during reset, rd_q cleared afterwards.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'hA5A5A5A5, 1'b0, '0, "reset_bus_z");
        probeComb(1'b1, 1'b0, 1'b1, 32'h0, "reset_rdq_zero");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].cs, vecs[i].we, vecs[i].oe, 1'b0, vecs[i].addr,
                          vecs[i].busIn, 1'b1, vecs[i].expBus, vecs[i].name);
        end

        // Back-to-back writes across the full address range, then reads in reverse.
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, AW'(a), 32'(a) * 32'h11111111,
                          1'b0, '0, $sformatf("b2b_wr%0d", a));
        end
        for (int a = 15; a >= 0; a--) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, AW'(a), 32'h0,
                          1'b0, '0, $sformatf("b2b_rd%0d", a));
        end

        // Combinational release and re-drive without an intervening edge.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 32'h0, 1'b0, '0, "rd_addr7");
        probeComb(1'b1, 1'b0, 1'b0, 32'h12121212, "comb_oe0_z");
        probeComb(1'b1, 1'b1, 1'b1, 32'h00000000, "comb_we1_z");
        probeComb(1'b0, 1'b0, 1'b1, 32'h00FF00FF, "comb_cs0_z");
        probeComb(1'b1, 1'b0, 1'b1, 32'h0,        "comb_redrive");

        // Reset mid-read: memory retained, read register cleared.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 1'b0, '0, "rst_seq_wr3");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 1'b0, '0, "rst_seq_rd3");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 32'h00000000, 1'b0, '0, "rst_seq_bus_z");
        probeComb(1'b1, 1'b0, 1'b1, 32'h0, "rst_seq_rdq_zero");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 32'h0, 1'b0, '0, "rst_seq_retained");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd11, 32'h0, 1'b0, '0, "rst_seq_rd11");

        driveControls(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
